// File: rtl/switch_poll_pkg.sv
// Shared types and constants for the switch poll master.
package switch_poll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_EVAL
   } poll_state_t;

   localparam int SWITCH_DATA_ADDR = 0;

   // Width of a down-counter that must hold poll_interval-1.
   function automatic int timer_width(input int poll_interval);
      return (poll_interval > 2) ? $clog2(poll_interval) : 1;
   endfunction

endpackage

// File: rtl/switch_sample_debounce.sv
// Debounces polled switch samples; publishes a value only after a run of identical samples.
module switch_sample_debounce #(
   parameter int DATA_WIDTH     = 10,
   parameter int STABLE_SAMPLES = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic                  sample_valid,
   output logic [DATA_WIDTH-1:0] switch_value,
   output logic                  switch_changed
);

   localparam int CW = $clog2(STABLE_SAMPLES + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_SAMPLES);

   logic [DATA_WIDTH-1:0] cand_q, cand_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic                  changed_q, changed_d;

   // Track the run length of the current candidate and promote it once the run is long enough.
   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      value_d   = value_q;
      changed_d = 1'b0;
      if (sample_valid) begin
         if (sample == cand_q) begin
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
         end else begin
            cand_d = sample;
            cnt_d  = CW'(1);
         end
         if ((cnt_d == CNT_FULL) && (cand_d != value_q)) begin
            value_d   = cand_d;
            changed_d = 1'b1;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_q    <= '0;
         cnt_q     <= '0;
         value_q   <= '0;
         changed_q <= 1'b0;
      end else begin
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         value_q   <= value_d;
         changed_q <= changed_d;
      end
   end

   assign switch_value   = value_q;
   assign switch_changed = changed_q;

endmodule

// File: rtl/switch_poll_master.sv
// Periodic Avalon-MM read initiator for the switch PIO, with debounce and sticky change irq.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for the interval timer to reach terminal count
//   REQ     | avm_read asserted until the slave drops waitrequest
//   WAIT    | fixed read latency; readdata captured on the last edge
//   EVAL    | captured sample handed to the debouncer for one cycle
module switch_poll_master
   import switch_poll_pkg::*;
#(
   parameter int POLL_INTERVAL  = 50000,
   parameter int READ_LATENCY   = 1,
   parameter int DATA_WIDTH     = 10,
   parameter int STABLE_SAMPLES = 3,
   parameter int SWITCH_ADDR    = SWITCH_DATA_ADDR
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   output logic [1:0]            avm_address,
   output logic                  avm_read,
   input  logic                  avm_waitrequest,
   input  logic [31:0]           avm_readdata,
   output logic [DATA_WIDTH-1:0] switch_value,
   output logic                  switch_changed,
   output logic                  irq,
   input  logic                  irq_ack
);

   localparam int TW = timer_width(POLL_INTERVAL);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);
   localparam logic [1:0] ADDR_C = 2'(SWITCH_ADDR);

   poll_state_t           state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [LW-1:0]         lat_q, lat_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  irq_q, irq_d;
   logic                  sample_valid;
   logic                  unused_rd;

   // Upper readdata bits carry nothing for this slave.
   assign unused_rd = ^avm_readdata;

   // Interval timer, read sequencing and sample capture.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      lat_d   = lat_q;
      data_d  = data_q;
      if (enable && (timer_q != '0)) timer_d = timer_q - TW'(1);
      case (state_q)
         ST_IDLE: begin
            if (enable && (timer_q == '0)) begin
               state_d = ST_REQ;
               timer_d = TIMER_RELOAD;
            end
         end
         ST_REQ: begin
            if (!avm_waitrequest) begin
               state_d = ST_WAIT;
               lat_d   = LAT_LAST;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               state_d = ST_EVAL;
               data_d  = avm_readdata[DATA_WIDTH-1:0];
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         ST_EVAL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky irq; a change strobe in the same cycle as an ack keeps it set.
   always_comb begin
      irq_d = switch_changed | (irq_q & ~irq_ack);
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         timer_q <= TIMER_RELOAD;
         lat_q   <= '0;
         data_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         lat_q   <= lat_d;
         data_q  <= data_d;
         irq_q   <= irq_d;
      end
   end

   assign sample_valid = (state_q == ST_EVAL);
   assign avm_read     = (state_q == ST_REQ);
   assign avm_address  = ADDR_C;
   assign irq          = irq_q;

   switch_sample_debounce #(
      .DATA_WIDTH     (DATA_WIDTH),
      .STABLE_SAMPLES (STABLE_SAMPLES)
   ) u_debounce (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample         (data_q),
      .sample_valid   (sample_valid),
      .switch_value   (switch_value),
      .switch_changed (switch_changed)
   );

endmodule

// File: tb/tb_switch_poll_master.sv
// Bench for switch_poll_master: transaction-level model plus directed scenarios.
module tb_switch_poll_master;

   localparam int PI = 8;
   localparam int RL = 1;
   localparam int DW = 10;
   localparam int SS = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          avm_waitrequest = 1'b0;
   logic          irq_ack = 1'b0;
   logic [31:0]   avm_readdata = '0;
   logic [1:0]    avm_address;
   logic          avm_read;
   logic [DW-1:0] switch_value;
   logic          switch_changed;
   logic          irq;
   logic [DW-1:0] sw_in = '0;

   int n_pass = 0;
   int n_total = 0;
   int n_chg = 0;

   always #5 clk = ~clk;

   switch_poll_master #(
      .POLL_INTERVAL  (PI),
      .READ_LATENCY   (RL),
      .DATA_WIDTH     (DW),
      .STABLE_SAMPLES (SS),
      .SWITCH_ADDR    (0)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .switch_value    (switch_value),
      .switch_changed  (switch_changed),
      .irq             (irq),
      .irq_ack         (irq_ack)
   );

   // Switch PIO slave: registered readdata, upper bits driven to ones.
   always @(posedge clk)
      if (avm_read && !avm_waitrequest) avm_readdata <= {22'h3FFFFF, sw_in};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model: phase 0 idle, 1 requesting, 2 read in flight (m_left edges to evaluation).
   int            m_phase = 0;
   int            m_timer = PI - 1;
   int            m_left = 0;
   logic [DW-1:0] m_pend = '0;
   logic [DW-1:0] m_value = '0;
   bit            m_changed = 1'b0;
   bit            m_irq = 1'b0;
   logic [DW-1:0] hist[$];

   function automatic void model_reset();
      m_phase = 0;
      m_timer = PI - 1;
      m_left = 0;
      m_value = '0;
      m_changed = 1'b0;
      m_irq = 1'b0;
      hist.delete();
   endfunction

   // Value becomes the sample once the last SS samples are all identical.
   function automatic void take_sample(input logic [DW-1:0] s);
      bit all_same;
      hist.push_back(s);
      if (hist.size() > SS) void'(hist.pop_front());
      if (hist.size() == SS) begin
         all_same = 1'b1;
         foreach (hist[i]) if (hist[i] != hist[0]) all_same = 1'b0;
         if (all_same && (hist[0] != m_value)) begin
            m_value = hist[0];
            m_changed = 1'b1;
         end
      end
   endfunction

   function automatic void model_step();
      bit chg_prev;
      chg_prev = m_changed;
      m_irq = chg_prev | (m_irq & !irq_ack);
      m_changed = 1'b0;
      case (m_phase)
         0: begin
            if (enable && m_timer == 0) begin
               m_phase = 1;
               m_timer = PI - 1;
            end else if (enable && m_timer > 0) begin
               m_timer--;
            end
         end
         1: begin
            if (enable && m_timer > 0) m_timer--;
            if (!avm_waitrequest) begin
               m_pend = sw_in;
               m_left = RL + 1;
               m_phase = 2;
            end
         end
         default: begin
            if (enable && m_timer > 0) m_timer--;
            m_left--;
            if (m_left == 0) begin
               take_sample(m_pend);
               m_phase = 0;
            end
         end
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("avm_read", avm_read, (m_phase == 1));
      check("avm_address", avm_address, 0);
      check("switch_value", switch_value, m_value);
      check("switch_changed", switch_changed, m_changed);
      check("irq", irq, m_irq);
      if (switch_changed === 1'b1) n_chg++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_read(input string name, output int n);
      n = 0;
      while (!avm_read && n < 100) begin
         tick();
         n++;
      end
      if (!avm_read) check(name, avm_read, 1);
   endtask

   task automatic wait_read_low(input string name);
      int n;
      n = 0;
      while (avm_read && n < 100) begin
         tick();
         n++;
      end
      if (avm_read) check(name, avm_read, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int n, cnt;
      // Scenario: constant 2A5, first poll timing, period, single update and irq.
      sw_in = 10'h2A5;
      enable = 1'b1;
      tick();
      check("reset_read", avm_read, 0);
      check("reset_value", switch_value, 0);
      check("reset_irq", irq, 0);
      do_reset();
      n_chg = 0;
      wait_read("first_poll_timeout", n);
      check("first_poll_latency", n, 8);
      wait_read_low("first_poll_low_timeout");
      wait_read("second_poll_timeout", n);
      check("poll_period", n + 1, 8);
      repeat (30) tick();
      check("t1_value", switch_value, 10'h2A5);
      check("t1_change_count", n_chg, 1);
      check("t1_irq", irq, 1);

      // Scenario: ack coincides with a new change strobe, then ack alone.
      sw_in = 10'h003;
      n = 0;
      while (!switch_changed && n < 80) begin
         tick();
         n++;
      end
      check("t4_strobe_seen", switch_changed, 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("t4_irq_set_wins", irq, 1);
      check("t4_value", switch_value, 10'h003);
      repeat (3) tick();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("t4_irq_cleared", irq, 0);

      // Scenario: alternating samples never settle.
      sw_in = 10'h001;
      do_reset();
      n_chg = 0;
      for (int k = 0; k < 8; k++) begin
         wait_read("t2_poll_timeout", n);
         sw_in = k[0] ? 10'h002 : 10'h001;
         wait_read_low("t2_low_timeout");
      end
      repeat (4) tick();
      check("t2_value", switch_value, 0);
      check("t2_change_count", n_chg, 0);
      check("t2_irq", irq, 0);

      // Scenario: waitrequest stall of five cycles.
      sw_in = 10'h155;
      avm_waitrequest = 1'b1;
      wait_read("t3_poll_timeout", n);
      cnt = 1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 5) avm_waitrequest = 1'b0;
         if (avm_read) cnt++;
      end
      check("t3_req_hold_cycles", cnt, 6);
      tick();
      check("t3_read_dropped", avm_read, 0);
      wait_read("t3_next_timeout", n);
      check("t3_next_poll_delay", n, 3);
      repeat (30) tick();
      check("t3_value", switch_value, 10'h155);

      // Scenario: enable dropped while the read is in flight.
      wait_read("t5_poll_timeout", n);
      tick();
      enable = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (avm_read) cnt++;
      end
      check("t5_no_read_disabled", cnt, 0);
      enable = 1'b1;
      wait_read("t5_resume_timeout", n);
      check("t5_resume_delay", n, 7);

      // Scenario: reset asserted while avm_read is high.
      wait_read_low("t6_low_timeout");
      wait_read("t6_poll_timeout", n);
      #1 reset_n = 1'b0;
      #1;
      check("t6_read_async_drop", avm_read, 0);
      check("t6_value_reset", switch_value, 0);
      check("t6_irq_reset", irq, 0);
      tick();
      reset_n = 1'b1;
      wait_read("t6_first_poll_timeout", n);
      check("t6_first_poll_latency", n, 8);
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
